wb_port_scheduler: RTL
======================

// Module: wb_port_scheduler
// PURPOSE
// - Owns the register-file write port: the C destination code and the busC data word feeding the C-bus decoder.
// - Arbitrates between two writeback requesters, the ALU stage and the memory-load stage; at most one write is issued per cycle.
// - The ALU stage is buffered in a small FIFO and the load stage has priority; the block also answers a hazard query for the decode stage.
// PARAMETERS
// - DATA_W      16  busC / requester data width
// - CODE_W      6   destination code width
// - FIFO_DEPTH  2   ALU holding FIFO entries (power of two, >=2)
// - STARVE_MAX  4   consecutive load wins while FIFO non-empty before ALU is forced
// - NOP_CODE    63  code driven when no write is issued
// PORTS
// - clk        in   1       system clock
// - rst_n      in   1       synchronous reset, active-low
// - alu_valid  in   1       ALU writeback request
// - alu_ready  out  1       ALU request accepted this cycle when valid&ready
// - alu_dest   in   CODE_W  ALU destination register code
// - alu_data   in   DATA_W  ALU result
// - mem_valid  in   1       load writeback request
// - mem_ready  out  1       load request accepted when valid&ready
// - mem_dest   in   CODE_W  load destination code
// - mem_data   in   DATA_W  load data
// - c_out      out  CODE_W  registered C code to the decoder
// - busc_out   out  DATA_W  registered busC word
// - drop_err   out  1       1-cycle pulse: an accepted request had dest >= 62
// - rd_addr    in   CODE_W  hazard query address from decode
// - rd_pending out  1       comb.: rd_addr has a queued or issuing write
// BEHAVIOUR
// - One clock; reset is synchronous and active-low; clock port is clk, reset port is rst_n.
// - Reset: c_out=NOP_CODE, busc_out=0, drop_err=0, FIFO empty, starve count=0, FSM=NORMAL. alu_ready=1 and mem_ready=1 apply from the first cycle after reset.
// - c_out/busc_out are registered. A write accepted or popped in cycle N appears in cycle N+1, with exactly 1 cycle of latency. In cycles with no issue, c_out=NOP_CODE.
// - alu_ready = FIFO not full, or (FIFO empty and bypass possible).
// - Bypass: FIFO empty, no load issuing this cycle -> ALU request goes straight to the outputs.
// - mem_ready = 0 when any of the following holds; otherwise 1:
//   - FSM=FORCE_ALU;
//   - mem_dest matches a valid FIFO entry. This is the WAW rule: the earlier ALU write must drain first.
// - Issue priority per cycle, in order:
//   1. FORCE_ALU pops the FIFO head.
//   2. An accepted load.
//   3. The FIFO head.
//   4. A bypassed ALU request.
// - An ALU request that is accepted but not issued is pushed. Push and pop in the same cycle are allowed; a full FIFO with a simultaneous pop still accepts the push.
// - Dest 62/63 from either requester: the request is accepted, nothing is issued or pushed, and drop_err pulses in cycle N+1.
// - FSM NORMAL -> FORCE_ALU when the starve count reaches STARVE_MAX. The count increments on each load issue while the FIFO is non-empty, and clears on any FIFO pop or when the FIFO is empty.
// - FORCE_ALU lasts exactly 1 cycle (one pop), then returns to NORMAL with the count cleared.
// - rd_pending = rd_addr matches any valid FIFO entry, or c_out when c_out != NOP_CODE. rd_addr >= 62 always returns 0.
// - FIFO pointers wrap modulo FIFO_DEPTH, with a separate count register for full/empty.
// - Reset mid-operation discards all queued writes; no partial write is emitted.
// STRUCTURE
// - Shared package ev22_pkg:
//   - CODE_W and DATA_W;
//   - NOP_CODE=63 and MEM_BUS_CODE=62;
//   - typedef wb_req_t {dest, data};
//   - enum sched_state_e {NORMAL, FORCE_ALU}.
// - One sub-module: wb_fifo (parameterised depth and width, valid/ready). It exports its per-entry dest bus for the match logic.
// - The top holds the FSM, starve counter, issue mux, output registers and comparators.
// TESTING
// - Reset: hold rst_n=0 for 2 clk -> c_out=63, busc_out=0, alu_ready=1, mem_ready=1, rd_pending=0.
// - Lone ALU: alu dest=5, data=0x1234 in cycle N -> c_out=5, busc_out=0x1234 in N+1, then c_out=63; FIFO stays empty.
// - Collision: ALU dest=3/0xAAAA and load dest=7/0x5555 in the same cycle.
//   - Outputs: 7/0x5555 in N+1, then 3/0xAAAA in N+2.
//   - rd_addr=3 -> rd_pending=1 through N+2, then 0.
// - WAW stall: FIFO holds dest=9, then load dest=9 -> mem_ready=0 until the ALU write issues; the load issues in the following cycle.
// - Starvation: fill the FIFO (2 entries) and hold mem_valid for 10 cycles with distinct dests.
//   - After 4 load issues, mem_ready=0 for 1 cycle and the ALU head issues.
//   - The pattern repeats until the FIFO is empty.
// - Drops and reset: alu dest=63 -> drop_err pulses, no write issued. Assert rst_n=0 with the FIFO full -> FIFO empty and c_out=63 next cycle.

Source files
------------

// File: rtl/wb_port_scheduler_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package ev22_pkg;

  localparam int unsigned CODE_W = 6;
  localparam int unsigned DATA_W = 16;

  localparam logic [CODE_W-1:0] NOP_CODE     = 6'd63;
  localparam logic [CODE_W-1:0] MEM_BUS_CODE = 6'd62;

  typedef struct packed {
    logic [CODE_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_ALU = 1'b1
  } sched_state_e;

  // Codes 62/63 are not real registers: writes to them are dropped.
  function automatic logic is_reserved(input logic [CODE_W-1:0] code);
    return code >= MEM_BUS_CODE;
  endfunction

endpackage

// File: rtl/wb_port_scheduler_if.sv
// Requester handshakes, C-bus outputs and hazard query of the writeback scheduler.
interface wb_port_scheduler_if;
  import ev22_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [CODE_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [CODE_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic [CODE_W-1:0] c_out;
  logic [DATA_W-1:0] busc_out;
  logic              drop_err;
  logic [CODE_W-1:0] rd_addr;
  logic              rd_pending;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output mem_valid, mem_dest, mem_data,
    output rd_addr,
    input  alu_ready, mem_ready, c_out, busc_out, drop_err, rd_pending
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  mem_valid, mem_dest, mem_data,
    input  rd_addr,
    output alu_ready, mem_ready, c_out, busc_out, drop_err, rd_pending
  );

endinterface

// File: rtl/wb_fifo.sv
// Small holding FIFO for writeback requests; exposes every entry's dest for match logic.
module wb_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DEST_W = 6,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [DEST_W-1:0] push_dest_i,
  input  logic [WORD_W-1:0] push_data_i,
  output logic              pop_valid_o,
  input  logic              pop_ready_i,
  output logic [DEST_W-1:0] head_dest_o,
  output logic [WORD_W-1:0] head_data_o,
  output logic [DEST_W-1:0] entry_dest_o [DEPTH],
  output logic [DEPTH-1:0]  entry_valid_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DEST_W-1:0] dest_q [DEPTH];
  logic [WORD_W-1:0] data_q [DEPTH];
  logic              do_push, do_pop;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CW'(DEPTH));
  assign pop_valid_o  = !empty_o;
  // A full FIFO that pops this cycle frees the slot for a same-cycle push.
  assign push_ready_o = !full_o || pop_ready_i;
  assign do_push      = push_valid_i && push_ready_o;
  assign do_pop       = pop_ready_i && !empty_o;
  assign head_dest_o  = dest_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign entry_dest_o = dest_q;

  always_comb begin
    logic [PW-1:0] off;
    off           = '0;
    entry_valid_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off              = PW'(i) - rd_ptr_q;
      entry_valid_o[i] = (CW'(off) < count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the count register alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      dest_q[wr_ptr_q] <= push_dest_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/wb_port_scheduler.sv
// Register-file write port owner: arbitrates ALU and load writebacks onto the C bus.
module wb_port_scheduler
  import ev22_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter int unsigned       STARVE_MAX = 4,
  parameter logic [CODE_W-1:0] NOP_CODE   = ev22_pkg::NOP_CODE
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_port_scheduler_if.slave  bus
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  sched_state_e      state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [CODE_W-1:0] c_q, c_d;
  logic [DATA_W-1:0] busc_q, busc_d;
  logic              drop_q, drop_d;

  logic              fifo_push, fifo_push_ready, fifo_pop_ready;
  logic              fifo_empty, fifo_full, fifo_pop_valid;
  logic [CODE_W-1:0] fifo_head_dest;
  logic [DATA_W-1:0] fifo_head_data;
  logic [CODE_W-1:0] fifo_dest [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld;

  logic force_alu, waw_hit, rd_hit;
  logic alu_drop, mem_drop, mem_ready, mem_acc, mem_issue;
  logic bypass_ok, alu_ready, alu_acc, alu_keep, fifo_popping;

  wb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DEST_W (CODE_W),
    .WORD_W (DATA_W)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_valid_i  (fifo_push),
    .push_ready_o  (fifo_push_ready),
    .push_dest_i   (bus.alu_dest),
    .push_data_i   (bus.alu_data),
    .pop_valid_o   (fifo_pop_valid),
    .pop_ready_i   (fifo_pop_ready),
    .head_dest_o   (fifo_head_dest),
    .head_data_o   (fifo_head_data),
    .entry_dest_o  (fifo_dest),
    .entry_valid_o (fifo_vld),
    .empty_o       (fifo_empty),
    .full_o        (fifo_full)
  );

  always_comb begin
    waw_hit = 1'b0;
    rd_hit  = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_dest[i] == bus.mem_dest)) waw_hit = 1'b1;
      if (fifo_vld[i] && (fifo_dest[i] == bus.rd_addr))  rd_hit  = 1'b1;
    end
  end

  // Handshake chain kept as plain assigns so the load decision settles before the ALU side.
  assign force_alu      = (state_q == FORCE_ALU);
  assign alu_drop       = is_reserved(bus.alu_dest);
  assign mem_drop       = is_reserved(bus.mem_dest);
  assign mem_ready      = !force_alu && !waw_hit;
  assign mem_acc        = bus.mem_valid && mem_ready;
  assign mem_issue      = mem_acc && !mem_drop;
  assign bypass_ok      = fifo_empty && !mem_issue;
  assign fifo_pop_ready = force_alu || !mem_issue;
  assign fifo_popping   = fifo_pop_valid && fifo_pop_ready;
  assign alu_ready      = fifo_push_ready || (fifo_empty && bypass_ok);
  assign alu_acc        = bus.alu_valid && alu_ready;
  assign alu_keep       = alu_acc && !alu_drop;
  assign fifo_push      = alu_keep && !bypass_ok;

  always_comb begin
    c_d      = NOP_CODE;
    busc_d   = '0;
    drop_d   = (alu_acc && alu_drop) || (mem_acc && mem_drop);
    starve_d = starve_q;
    state_d  = state_q;

    if (fifo_pop_valid && force_alu) begin
      c_d    = fifo_head_dest;
      busc_d = fifo_head_data;
    end else if (mem_issue) begin
      c_d    = bus.mem_dest;
      busc_d = bus.mem_data;
    end else if (fifo_pop_valid) begin
      c_d    = fifo_head_dest;
      busc_d = fifo_head_data;
    end else if (alu_keep) begin
      c_d    = bus.alu_dest;
      busc_d = bus.alu_data;
    end

    if (fifo_popping || fifo_empty) begin
      starve_d = '0;
    end else if (mem_issue && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end

    case (state_q)
      NORMAL:    if (starve_d == SW'(STARVE_MAX)) state_d = FORCE_ALU;
      FORCE_ALU: state_d = NORMAL;
      default:   state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= NORMAL;
      starve_q <= '0;
      c_q      <= NOP_CODE;
      busc_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      c_q      <= c_d;
      busc_q   <= busc_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.alu_ready  = alu_ready;
  assign bus.mem_ready  = mem_ready;
  assign bus.c_out      = c_q;
  assign bus.busc_out   = busc_q;
  assign bus.drop_err   = drop_q;
  assign bus.rd_pending = !is_reserved(bus.rd_addr) &&
                          (rd_hit || ((c_q != NOP_CODE) && (c_q == bus.rd_addr)));

endmodule
